depth_test_fb_writer: RTL

//  Consumer end of the rasterizer fragment-write interface (addr, write enable, depth, colour).

---
 rtl/depth_test_fb_writer.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/depth_test_fb_writer.sv
// -----------------------------------------------------------------------------
// depth_test_fb_writer
//
// Consumer end of the rasterizer fragment-write interface. Owns the on-chip
// depth buffer and runs a read / compare / write depth test on every accepted
// fragment. Only fragments that are strictly closer than the stored depth are
// written to the depth buffer and forwarded to the colour framebuffer port.
// A clear request fills the depth buffer with "far" (all ones) and emits one
// colour write of CLEAR_COLOR per pixel.
//
// Ports
//   clk            in   rising-edge system clock
//   rst            in   asynchronous, active-high reset
//   i_fb_addr      in   fragment pixel address
//   i_fb_write_en  in   fragment valid this cycle
//   i_depth        in   fragment depth (unsigned, smaller = closer)
//   i_color        in   fragment colour
//   i_clear        in   one-cycle clear request
//   o_ready        out  fragments are accepted this cycle
//   o_clear_done   out  one-cycle pulse in the cycle after the last clear write
//   o_fb_addr      out  colour framebuffer write address
//   o_fb_we        out  colour framebuffer write strobe
//   o_fb_color     out  colour framebuffer write data
//   o_pass_count   out  fragments passed since the last clear (wraps)
// -----------------------------------------------------------------------------
module depth_test_fb_writer #(
  parameter int                    DATAWIDTH     = 12,
  parameter int                    COLORWIDTH    = 4,
  parameter int                    ADDRWIDTH     = 16,
  parameter int                    SCREEN_WIDTH  = 160,
  parameter int                    SCREEN_HEIGHT = 120,
  parameter logic [COLORWIDTH-1:0] CLEAR_COLOR   = {COLORWIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDRWIDTH-1:0]  i_fb_addr,
  input  logic                  i_fb_write_en,
  input  logic [DATAWIDTH-1:0]  i_depth,
  input  logic [COLORWIDTH-1:0] i_color,
  input  logic                  i_clear,
  output logic                  o_ready,
  output logic                  o_clear_done,
  output logic [ADDRWIDTH-1:0]  o_fb_addr,
  output logic                  o_fb_we,
  output logic [COLORWIDTH-1:0] o_fb_color,
  output logic [31:0]           o_pass_count
);

  localparam int                   FB_SIZE   = SCREEN_WIDTH * SCREEN_HEIGHT;
  localparam int                   MEM_AW    = (FB_SIZE > 1) ? $clog2(FB_SIZE) : 1;
  localparam logic [ADDRWIDTH:0]   FB_SIZE_X = (ADDRWIDTH+1)'(FB_SIZE);
  localparam logic [ADDRWIDTH-1:0] FB_LAST   = ADDRWIDTH'(FB_SIZE - 1);
  localparam logic [ADDRWIDTH-1:0] ADDR_ONE  = {{(ADDRWIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATAWIDTH-1:0] DEPTH_FAR = {DATAWIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_CLEAR_WAIT = 2'd1,
    ST_CLEAR      = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ADDRWIDTH-1:0]  clr_addr_q, clr_addr_d;
  logic                  clr_last_q, clr_last_d;

  // S1 stage: fragment whose depth read is returning this cycle
  logic                  s1_valid_q, s1_valid_d;
  logic [ADDRWIDTH-1:0]  s1_addr_q, s1_addr_d;
  logic [DATAWIDTH-1:0]  s1_depth_q, s1_depth_d;
  logic [COLORWIDTH-1:0] s1_color_q, s1_color_d;

  // Forwarding register: the depth written by S1 last cycle, which the RAM
  // read issued in that same cycle could not yet observe (read-first RAM).
  logic                  fwd_valid_q, fwd_valid_d;
  logic [ADDRWIDTH-1:0]  fwd_addr_q, fwd_addr_d;
  logic [DATAWIDTH-1:0]  fwd_depth_q, fwd_depth_d;

  // S2 / output registers
  logic                  fb_we_q, fb_we_d;
  logic [ADDRWIDTH-1:0]  fb_addr_q, fb_addr_d;
  logic [COLORWIDTH-1:0] fb_color_q, fb_color_d;
  logic                  clear_done_q, clear_done_d;
  logic [31:0]           pass_count_q, pass_count_d;

  // Depth RAM and its access signals
  logic [DATAWIDTH-1:0]  depth_mem [FB_SIZE];
  logic [DATAWIDTH-1:0]  ram_rdata_q;
  logic [MEM_AW-1:0]     ram_raddr_s;
  logic [MEM_AW-1:0]     ram_waddr_s;
  logic [DATAWIDTH-1:0]  ram_wdata_s;
  logic                  ram_we_s;

  logic                  in_range_s;
  logic                  accept_s;
  logic [DATAWIDTH-1:0]  cmp_depth_s;
  logic                  pass_s;

  assign o_ready      = (state_q == ST_IDLE);
  assign o_clear_done = clear_done_q;
  assign o_fb_addr    = fb_addr_q;
  assign o_fb_we      = fb_we_q;
  assign o_fb_color   = fb_color_q;
  assign o_pass_count = pass_count_q;

  // S0 acceptance, S1 depth compare with forwarding, RAM port selection
  always_comb begin
    in_range_s = ({1'b0, i_fb_addr} < FB_SIZE_X);
    accept_s   = i_fb_write_en && o_ready && in_range_s;

    if (in_range_s) begin
      ram_raddr_s = i_fb_addr[MEM_AW-1:0];
    end else begin
      ram_raddr_s = {MEM_AW{1'b0}};
    end

    if (fwd_valid_q && (fwd_addr_q == s1_addr_q)) begin
      cmp_depth_s = fwd_depth_q;
    end else begin
      cmp_depth_s = ram_rdata_q;
    end

    // Strict compare: equal depth fails, so the first fragment drawn wins
    pass_s = s1_valid_q && (s1_depth_q < cmp_depth_s);

    // S1 is always empty while clearing, so the two writers never collide
    if (state_q == ST_CLEAR) begin
      ram_we_s    = 1'b1;
      ram_waddr_s = clr_addr_q[MEM_AW-1:0];
      ram_wdata_s = DEPTH_FAR;
    end else begin
      ram_we_s    = pass_s;
      ram_waddr_s = s1_addr_q[MEM_AW-1:0];
      ram_wdata_s = s1_depth_q;
    end
  end

  // Clear FSM next-state logic
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    clr_last_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_clear) begin
          state_d = ST_CLEAR_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR_WAIT: begin
        // S0 is closed, so once S1 drains no fragment can still write the RAM
        if (!s1_valid_q) begin
          state_d    = ST_CLEAR;
          clr_addr_d = {ADDRWIDTH{1'b0}};
        end else begin
          state_d = ST_CLEAR_WAIT;
        end
      end
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + ADDR_ONE;
        if (clr_addr_q == FB_LAST) begin
          state_d    = ST_IDLE;
          clr_last_d = 1'b1;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pipeline register next-state: S1 capture, forwarding and output stage
  always_comb begin
    s1_valid_d  = accept_s;
    s1_addr_d   = i_fb_addr;
    s1_depth_d  = i_depth;
    s1_color_d  = i_color;

    fwd_valid_d = pass_s;
    fwd_addr_d  = s1_addr_q;
    fwd_depth_d = s1_depth_q;

    if (state_q == ST_CLEAR) begin
      fb_we_d    = 1'b1;
      fb_addr_d  = clr_addr_q;
      fb_color_d = CLEAR_COLOR;
    end else begin
      fb_we_d    = pass_s;
      fb_addr_d  = s1_addr_q;
      fb_color_d = s1_color_q;
    end

    // The done pulse trails the last registered clear write by one cycle
    clear_done_d = clr_last_q;

    if (clr_last_q) begin
      pass_count_d = 32'd0;
    end else begin
      pass_count_d = pass_count_q + {31'd0, pass_s};
    end
  end

  // State and pipeline registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      clr_addr_q   <= {ADDRWIDTH{1'b0}};
      clr_last_q   <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_addr_q    <= {ADDRWIDTH{1'b0}};
      s1_depth_q   <= {DATAWIDTH{1'b0}};
      s1_color_q   <= {COLORWIDTH{1'b0}};
      fwd_valid_q  <= 1'b0;
      fwd_addr_q   <= {ADDRWIDTH{1'b0}};
      fwd_depth_q  <= {DATAWIDTH{1'b0}};
      fb_we_q      <= 1'b0;
      fb_addr_q    <= {ADDRWIDTH{1'b0}};
      fb_color_q   <= {COLORWIDTH{1'b0}};
      clear_done_q <= 1'b0;
      pass_count_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      clr_last_q   <= clr_last_d;
      s1_valid_q   <= s1_valid_d;
      s1_addr_q    <= s1_addr_d;
      s1_depth_q   <= s1_depth_d;
      s1_color_q   <= s1_color_d;
      fwd_valid_q  <= fwd_valid_d;
      fwd_addr_q   <= fwd_addr_d;
      fwd_depth_q  <= fwd_depth_d;
      fb_we_q      <= fb_we_d;
      fb_addr_q    <= fb_addr_d;
      fb_color_q   <= fb_color_d;
      clear_done_q <= clear_done_d;
      pass_count_q <= pass_count_d;
    end
  end

  // Depth RAM: synchronous read, read-first on same-address collision
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      depth_mem[ram_waddr_s] <= ram_wdata_s;
    end
    ram_rdata_q <= depth_mem[ram_raddr_s];
  end

endmodule
